eucl_dist_min_select: RTL and testbench
=======================================

Name: eucl_dist_min_select

Overview:
- Downstream consumer of the Euclidean-distance stage. Accepts one `distance` word per candidate code sequence, serially over `numCand` accepted beats per frame.
- Tracks the minimum and returns the winning candidate index and its distance. Optionally also returns the best-vs-second-best margin as a reliability metric.
- Feeds the symbol-decision / error-tracking logic through a valid/ready result handshake.

Parameters:
- distWidth, 8, width of incoming distance (matches distance-stage outWidth).
- numCand, 8, candidates per frame; legal range 1..256.
- idxWidth, localparam = max(1, $clog2(numCand)), width of candidate index.

Ports:
- clk  in  1  single block clock, all state on rising edge
- rstb  in  1  asynchronous active-low reset
- dist_in  in  distWidth  unsigned candidate distance, order of arrival = candidate index
- dist_valid  in  1  dist_in valid
- dist_ready  out  1  block accepts dist_in this cycle
- best_idx  out  idxWidth  index of minimum-distance candidate
- best_dist  out  distWidth  minimum distance
- margin  out  distWidth  second-best minus best distance (feature-dependent)
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result

Behaviour:
- Interface: one clock `clk`; reset `rstb` is asynchronous, active-low. Asserting it clears all state immediately, independent of clk.
- Reset values:
  - state=IDLE, cnt=0, res_valid=0.
  - best_idx=0, best_dist=0, margin=0.
  - Internal second-best register = all-ones.
- Handshakes:
  - Accept = dist_valid & dist_ready.
  - dist_ready = (state != HOLD), combinational from state; it is 1 during and after reset.
  - Result transfer = res_valid & res_ready.
- States:
  - IDLE: on accept, load best=dist_in, best_idx=0, second=all-ones, cnt=1. Go to HOLD if numCand==1, else ACCUM. No accept: stay.
  - ACCUM: on accept, compare dist_in against best/second using candidate index cnt, then cnt++. When the accepted beat is the numCand-1'th index, go to HOLD. Cycles with dist_valid low (bubbles) change nothing.
  - HOLD: res_valid=1. best_idx, best_dist and margin are stable and registered. On res_ready, go to IDLE, res_valid=0, cnt=0.
- Compare rule, strictly unsigned:
  - If dist_in < best: second=best; best=dist_in; best_idx=cnt.
  - Else if dist_in < second: second=dist_in.
  - Ties keep the earlier (lower) index.
- Output update: best_idx, best_dist and margin are written only on the HOLD entry edge. They hold their last result in IDLE/ACCUM, so mid-frame updates are never visible on the ports.
- Margin: second − best, unsigned, distWidth bits; never negative by construction. With numCand==1 it is all-ones − best.
- Latency and throughput:
  - res_valid rises on the cycle after the final accepted beat.
  - Minimum frame period is numCand+1 cycles with res_ready held high.
- Overlap: no overlap between HOLD and new input; dist_ready=0 throughout HOLD, including the cycle res_ready is sampled.
- Reset mid-frame: partial frame discarded; the next accepted beat is candidate 0.
- Counter: cnt width idxWidth+1; never wraps past numCand-1 within a frame.

Optional Feature:
- Macro: EUCL_MIN_SECOND_EN.
- Defined: second-best register and margin logic present as above.
- Undefined:
  - No second-best register.
  - margin port driven constant 0.
  - best_idx / best_dist behaviour unchanged.

Decomposition:
- Shared package eucl_dist_pkg:
  - typedef enum logic [1:0] {IDLE, ACCUM, HOLD} min_sel_state_t.
  - Default widths shared with the distance stage (DIST_WIDTH=8).
- One natural sub-module, eucl_min_cmp: combinational compare/update cell.
  - Inputs: dist_in, best, second, cnt.
  - Outputs: next best, next second, next idx, take flag.
  - Instantiated once.

Test Plan:
All scenarios use numCand=4, distWidth=8, macro defined unless noted.
1. Frame 40,12,30,25 with res_ready=1 → res_valid one cycle after 4th accept; best_idx=1, best_dist=12, margin=13.
2. Tie frame 7,7,9,20 → best_idx=0, best_dist=7, margin=0.
3. Frame 50,60,70,5 followed by res_ready=0 for 5 cycles → res_valid held, dist_ready=0, outputs stable (idx 3, dist 5, margin 45); after res_ready pulse, dist_ready=1 next cycle and a new frame is accepted.
4. Frame 9,3,3,8 with dist_valid low 2 cycles between each beat → result identical to back-to-back: idx 1, dist 3, margin 0.
5. Assert rstb low asynchronously after 2 accepted beats (100,1) → all outputs 0 immediately; then frame 20,10,15,11 → idx 1, dist 10, margin 1.
6. Macro undefined, frame 255,255,255,255 → best_idx=0, best_dist=255, margin=0; repeat with frame 40,12,30,25 → margin=0.

Source files
------------

// File: rtl/eucl_dist_pkg.sv
// Shared types and default widths for the Euclidean-distance datapath.
// Used by the minimum-select stage and its compare cell.
package eucl_dist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } min_sel_state_t;

  localparam int DIST_WIDTH = 8;
  localparam int NUM_CAND   = 8;

  // Index width for n candidates, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eucl_min_cmp.sv
// Combinational compare/update cell for the running best / second-best distance.
// Second-best tracking is present only when EUCL_MIN_SECOND_EN is defined.
module eucl_min_cmp
  import eucl_dist_pkg::*;
#(
  parameter int distWidth = DIST_WIDTH,
  parameter int idxWidth  = 3
) (
  input  logic [distWidth-1:0] dist_in,
  input  logic [distWidth-1:0] best,
`ifdef EUCL_MIN_SECOND_EN
  input  logic [distWidth-1:0] second,
  output logic [distWidth-1:0] nxt_second,
`endif
  input  logic [idxWidth-1:0]  cnt,
  input  logic [idxWidth-1:0]  cur_idx,
  output logic [distWidth-1:0] nxt_best,
  output logic [idxWidth-1:0]  nxt_idx,
  output logic                 take
);

  // Strict less-than so that ties keep the earlier (lower) index.
  always_comb begin
    take     = (dist_in < best);
    nxt_best = best;
    nxt_idx  = cur_idx;
`ifdef EUCL_MIN_SECOND_EN
    nxt_second = second;
`endif
    if (take) begin
      nxt_best = dist_in;
      nxt_idx  = cnt;
`ifdef EUCL_MIN_SECOND_EN
      nxt_second = best;
    end else if (dist_in < second) begin
      nxt_second = dist_in;
`endif
    end else begin
      nxt_best = best;
      nxt_idx  = cur_idx;
    end
  end

endmodule

// File: rtl/eucl_dist_min_select.sv
// Minimum-distance selector: scans numCand distances per frame and returns the
// winning index, its distance and (with EUCL_MIN_SECOND_EN) the second-best margin.
module eucl_dist_min_select
  import eucl_dist_pkg::*;
#(
  parameter int distWidth = DIST_WIDTH,
  parameter int numCand   = NUM_CAND
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic [distWidth-1:0]            dist_in,
  input  logic                            dist_valid,
  output logic                            dist_ready,
  output logic [idx_width(numCand)-1:0]   best_idx,
  output logic [distWidth-1:0]            best_dist,
  output logic [distWidth-1:0]            margin,
  output logic                            res_valid,
  input  logic                            res_ready
);

  localparam int idxWidth = idx_width(numCand);
  localparam int cntWidth = idxWidth + 1;
  localparam logic [cntWidth-1:0] LAST_CNT = cntWidth'(numCand - 1);
  localparam bit ONE_CAND = (numCand == 1);

  min_sel_state_t state_r, state_nxt_s;

  logic [cntWidth-1:0]  cnt_r;
  logic [distWidth-1:0] acc_best_r;
  logic [idxWidth-1:0]  acc_idx_r;
  logic [idxWidth-1:0]  best_idx_r;
  logic [distWidth-1:0] best_dist_r;

  logic                 accept_s;
  logic                 is_last_s;
  logic                 upd_best_s;
  logic                 dist_ready_s;
  logic                 res_valid_s;
  logic [distWidth-1:0] best_in_s;
  logic [idxWidth-1:0]  cur_idx_s;
  logic [idxWidth-1:0]  cnt_idx_s;
  logic [distWidth-1:0] nxt_best_s;
  logic [idxWidth-1:0]  nxt_idx_s;
  logic                 take_s;

`ifdef EUCL_MIN_SECOND_EN
  logic [distWidth-1:0] second_r;
  logic [distWidth-1:0] second_in_s;
  logic [distWidth-1:0] nxt_second_s;
  logic [distWidth-1:0] margin_r;
`endif

  assign accept_s   = dist_valid & dist_ready_s;
  assign cnt_idx_s  = cnt_r[idxWidth-1:0];
  assign upd_best_s = take_s | (state_r == IDLE);

  // Frame start compares against an all-ones seed, which loads the first beat
  // exactly as an explicit load would (ties with all-ones change nothing).
  always_comb begin
    best_in_s = acc_best_r;
    cur_idx_s = acc_idx_r;
    is_last_s = (cnt_r == LAST_CNT);
`ifdef EUCL_MIN_SECOND_EN
    second_in_s = second_r;
`endif
    if (state_r == IDLE) begin
      best_in_s = '1;
      cur_idx_s = '0;
      is_last_s = ONE_CAND;
`ifdef EUCL_MIN_SECOND_EN
      second_in_s = '1;
`endif
    end else begin
      best_in_s = acc_best_r;
      cur_idx_s = acc_idx_r;
    end
  end

  eucl_min_cmp #(
    .distWidth (distWidth),
    .idxWidth  (idxWidth)
  ) u_cmp (
    .dist_in    (dist_in),
    .best       (best_in_s),
`ifdef EUCL_MIN_SECOND_EN
    .second     (second_in_s),
    .nxt_second (nxt_second_s),
`endif
    .cnt        (cnt_idx_s),
    .cur_idx    (cur_idx_s),
    .nxt_best   (nxt_best_s),
    .nxt_idx    (nxt_idx_s),
    .take       (take_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = ONE_CAND ? HOLD : ACCUM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s && is_last_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake decode: input is blocked for the whole result hold.
  always_comb begin
    dist_ready_s = 1'b1;
    res_valid_s  = 1'b0;
    case (state_r)
      HOLD: begin
        dist_ready_s = 1'b0;
        res_valid_s  = 1'b1;
      end
      default: begin
        dist_ready_s = 1'b1;
        res_valid_s  = 1'b0;
      end
    endcase
  end

  // Running accumulation and result registers; ports only change on HOLD entry.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_r       <= {cntWidth{1'b0}};
      acc_best_r  <= {distWidth{1'b0}};
      acc_idx_r   <= {idxWidth{1'b0}};
      best_idx_r  <= {idxWidth{1'b0}};
      best_dist_r <= {distWidth{1'b0}};
`ifdef EUCL_MIN_SECOND_EN
      second_r    <= {distWidth{1'b1}};
      margin_r    <= {distWidth{1'b0}};
`endif
    end else begin
      if (accept_s) begin
        cnt_r <= cnt_r + cntWidth'(1);
        if (upd_best_s) begin
          acc_best_r <= nxt_best_s;
          acc_idx_r  <= nxt_idx_s;
        end
`ifdef EUCL_MIN_SECOND_EN
        second_r <= nxt_second_s;
`endif
        if (is_last_s) begin
          best_idx_r  <= nxt_idx_s;
          best_dist_r <= nxt_best_s;
`ifdef EUCL_MIN_SECOND_EN
          margin_r    <= nxt_second_s - nxt_best_s;
`endif
        end
      end else if ((state_r == HOLD) && res_ready) begin
        cnt_r <= {cntWidth{1'b0}};
      end
    end
  end

  assign dist_ready = dist_ready_s;
  assign res_valid  = res_valid_s;
  assign best_idx   = best_idx_r;
  assign best_dist  = best_dist_r;
`ifdef EUCL_MIN_SECOND_EN
  assign margin     = margin_r;
`else
  assign margin     = {distWidth{1'b0}};
`endif

endmodule

// File: tb/tb_eucl_dist_min_select.sv
// Self-checking bench for eucl_dist_min_select (numCand=4, distWidth=8).
// Expected margin follows EUCL_MIN_SECOND_EN as compiled.
module tb_eucl_dist_min_select;

  logic       clk;
  logic       rstb;
  logic [7:0] dist_in;
  logic       dist_valid;
  logic       dist_ready;
  logic [1:0] best_idx;
  logic [7:0] best_dist;
  logic [7:0] margin;
  logic       res_valid;
  logic       res_ready;

  int errors = 0;
  int checks = 0;

  logic [7:0] fr [4];
  int ei, ed, em;
  int prev_d;

  eucl_dist_min_select #(.distWidth(8), .numCand(4)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .dist_in    (dist_in),
    .dist_valid (dist_valid),
    .dist_ready (dist_ready),
    .best_idx   (best_idx),
    .best_dist  (best_dist),
    .margin     (margin),
    .res_valid  (res_valid),
    .res_ready  (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: first minimum wins; second is the smallest of the remaining values.
  function automatic void model(input logic [7:0] f [4], output int bi, output int bd, output int mg);
    int sec;
    bi = 0;
    for (int i = 1; i < 4; i++) if (f[i] < f[bi]) bi = i;
    bd = f[bi];
    sec = 255;
    for (int j = 0; j < 4; j++) if (j != bi && f[j] < sec) sec = f[j];
`ifdef EUCL_MIN_SECOND_EN
    mg = sec - bd;
`else
    mg = 0;
`endif
  endfunction

  task automatic set_frame(input int a, input int b, input int c, input int d);
    fr[0] = 8'(a); fr[1] = 8'(b); fr[2] = 8'(c); fr[3] = 8'(d);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!dist_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!dist_ready) chk("ready_timeout", {31'd0, dist_ready}, 32'd1);
  endtask

  task automatic send_beat(input logic [7:0] v);
    wait_ready();
    dist_in = v;
    dist_valid = 1'b1;
    @(posedge clk); #1;
    dist_valid = 1'b0;
    dist_in = $urandom_range(0, 255);
  endtask

  task automatic run_frame(input int gap, input bit rr_high);
    model(fr, ei, ed, em);
    res_ready = rr_high;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (gap) begin @(posedge clk); #1; end
      send_beat(fr[i]);
      if (i == 0) chk("out_stable_midframe", best_dist, prev_d);
      if (i < 3) chk("no_early_valid", res_valid, 1'b0);
    end
    chk("res_valid_latency", res_valid, 1'b1);
    chk("dist_ready_in_hold", dist_ready, 1'b0);
    chk("best_idx", best_idx, ei);
    chk("best_dist", best_dist, ed);
    chk("margin", margin, em);
    prev_d = ed;
    if (rr_high) begin
      @(posedge clk); #1;
      chk("res_valid_drop", res_valid, 1'b0);
      chk("dist_ready_back", dist_ready, 1'b1);
      chk("best_dist_kept", best_dist, ed);
      res_ready = 1'b0;
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("release_valid", res_valid, 1'b0);
    chk("release_ready", dist_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b0;
    dist_in = 8'd0;
    dist_valid = 1'b0;
    res_ready = 1'b0;
    prev_d = 0;
    #12;
    chk("rst_best_idx", best_idx, 0);
    chk("rst_best_dist", best_dist, 0);
    chk("rst_margin", margin, 0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_dist_ready", dist_ready, 1'b1);
    rstb = 1'b1;
    @(posedge clk); #1;

    // Basic frame with res_ready held high.
    set_frame(40, 12, 30, 25);
    run_frame(0, 1'b1);

    // Tie on the minimum keeps the lower index.
    set_frame(7, 7, 9, 20);
    run_frame(0, 1'b0);
    release_result();

    // Downstream stall: result held and input blocked.
    set_frame(50, 60, 70, 5);
    run_frame(0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall_valid", res_valid, 1'b1);
      chk("stall_ready", dist_ready, 1'b0);
      chk("stall_idx", best_idx, ei);
    end
    chk("stall_margin", margin, em);
    release_result();

    // Bubbles between beats.
    set_frame(9, 3, 3, 8);
    run_frame(2, 1'b0);
    release_result();

    // Asynchronous reset mid-frame discards the partial frame.
    send_beat(8'd100);
    send_beat(8'd1);
    #2 rstb = 1'b0;
    #1;
    chk("async_rst_idx", best_idx, 0);
    chk("async_rst_dist", best_dist, 0);
    chk("async_rst_margin", margin, 0);
    chk("async_rst_valid", res_valid, 1'b0);
    chk("async_rst_ready", dist_ready, 1'b1);
    #3 rstb = 1'b1;
    @(posedge clk); #1;
    prev_d = 0;
    set_frame(20, 10, 15, 11);
    run_frame(0, 1'b0);
    release_result();

    // All-ones frame and a repeat of the basic frame.
    set_frame(255, 255, 255, 255);
    run_frame(0, 1'b0);
    release_result();
    set_frame(40, 12, 30, 25);
    run_frame(1, 1'b0);
    release_result();

    // Randomized frames, half of them drawn from a tiny range to force ties.
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < 4; i++)
        fr[i] = (f % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      run_frame($urandom_range(0, 2), 1'($urandom_range(0, 1)));
      if (res_valid) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        release_result();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
